// File: rtl/fconv_sched.sv
`default_nettype none
// fconv_sched: credit-gated round-robin issue of two requesters into one pipelined ftoi/itof unit.
// Optional macro FCONV_FIXED_PRIO_EN: requester 0 always wins when both are eligible.
module fconv_sched #(
    parameter int LAT    = 2,
    parameter int RDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_src,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_src,
    output logic        unit_valid,
    output logic        unit_op,
    output logic [31:0] unit_src,
    input  logic [31:0] unit_result,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_data,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_data,
    output logic        busy
);
    localparam int              PW     = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam logic [4:0]      DEPTH5 = 5'(RDEPTH);
    localparam logic [PW-1:0]   LAST   = PW'(RDEPTH - 1);

    logic [LAT-1:0]   trk_v, trk_v_nxt, trk_id, trk_id_nxt;
    logic [1:0][4:0]  infl, occ, occ_nxt;
    logic [1:0][31:0] rdata;
    logic [1:0]       elig, grant, push, pop;
    logic             issue;
    logic             busy_r;

    // Tokens still in the unit count against the owner's buffer space.
    always_comb begin
        infl = '0;
        for (int k = 0; k < LAT; k++) begin
            if (trk_v[k]) begin
                if (trk_id[k]) infl[1] = infl[1] + 5'd1;
                else           infl[0] = infl[0] + 5'd1;
            end
        end
    end

    assign elig[0] = req0_valid & ((occ[0] + infl[0]) < DEPTH5);
    assign elig[1] = req1_valid & ((occ[1] + infl[1]) < DEPTH5);

`ifdef FCONV_FIXED_PRIO_EN
    assign grant[0] = elig[0];
    assign grant[1] = elig[1] & ~elig[0];
`else
    logic prio;
    assign grant[0] = elig[0] & (~elig[1] | ~prio);
    assign grant[1] = elig[1] & (~elig[0] |  prio);

    always_ff @(posedge clk) begin
        if (rst)        prio <= 1'b0;
        else if (issue) prio <= grant[0];
    end
`endif

    assign issue      = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign unit_valid = issue;
    assign unit_op    = grant[0] ? req0_op  : (grant[1] ? req1_op  : 1'b0);
    assign unit_src   = grant[0] ? req0_src : (grant[1] ? req1_src : 32'd0);

    always_comb begin
        trk_v_nxt     = '0;
        trk_id_nxt    = '0;
        trk_v_nxt[0]  = issue;
        trk_id_nxt[0] = grant[1];
        for (int k = 1; k < LAT; k++) begin
            trk_v_nxt[k]  = trk_v[k-1];
            trk_id_nxt[k] = trk_id[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_v  <= '0;
            trk_id <= '0;
        end else begin
            trk_v  <= trk_v_nxt;
            trk_id <= trk_id_nxt;
        end
    end

    assign push[0] = trk_v[LAT-1] & ~trk_id[LAT-1];
    assign push[1] = trk_v[LAT-1] &  trk_id[LAT-1];
    assign pop[0]  = res0_valid & res0_ready;
    assign pop[1]  = res1_valid & res1_ready;

    for (genvar r = 0; r < 2; r++) begin : g_rbuf
        logic [31:0]   mem [RDEPTH];
        logic [PW-1:0] rd, wr;
        logic [4:0]    cnt;

        assign occ[r]     = cnt;
        assign occ_nxt[r] = cnt + {4'd0, push[r]} - {4'd0, pop[r]};
        assign rdata[r]   = (cnt != 5'd0) ? mem[rd] : 32'd0;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd  <= '0;
                wr  <= '0;
                cnt <= '0;
            end else begin
                if (push[r]) begin
                    mem[wr] <= unit_result;
                    wr      <= (wr == LAST) ? '0 : wr + 1'b1;
                end
                if (pop[r]) rd <= (rd == LAST) ? '0 : rd + 1'b1;
                cnt <= occ_nxt[r];
            end
        end
    end

    assign res0_valid = (occ[0] != 5'd0);
    assign res1_valid = (occ[1] != 5'd0);
    assign res0_data  = rdata[0];
    assign res1_data  = rdata[1];

    always_ff @(posedge clk) begin
        if (rst) busy_r <= 1'b0;
        else     busy_r <= (|trk_v_nxt) | (occ_nxt[0] != 5'd0) | (occ_nxt[1] != 5'd0);
    end

    assign busy = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_fconv_sched.sv
`default_nettype none
// tb_fconv_sched: directed vectors against fconv_sched (LAT=2, RDEPTH=2) with an ftoi lookup model.
module tb_fconv_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_src;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_src;
    logic        unit_valid, unit_op;
    logic [31:0] unit_src, unit_result;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0] res0_data, res1_data;
    logic        busy;
    logic [31:0] p1 = '0, p2 = '0;
    int          total = 0, bad = 0;
    int          o0 = 0, o1 = 0;

    always #5 clk = ~clk;

    fconv_sched #(.LAT(2), .RDEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_src(req0_src),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_src(req1_src),
        .unit_valid(unit_valid), .unit_op(unit_op), .unit_src(unit_src), .unit_result(unit_result),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
        .busy(busy)
    );

    function automatic logic [31:0] ftoi_model(input logic [31:0] s);
        case (s)
            32'h3FC00000: return 32'h00000002;
            32'h40400000: return 32'h00000003;
            32'hC0200000: return 32'hFFFFFFFD;
            default:      return ~s;
        endcase
    endfunction

    // Two-stage conversion unit model; not reset, so stale results keep arriving after rst.
    always @(posedge clk) begin
        p1 <= ftoi_model(unit_src);
        p2 <= p1;
    end
    assign unit_result = p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Accepted-but-unconsumed operations per requester may never exceed the buffer depth.
    always @(posedge clk) begin
        if (rst) begin
            o0 = 0;
            o1 = 0;
        end else begin
            o0 = o0 + int'(req0_valid && req0_ready) - int'(res0_valid && res0_ready);
            o1 = o1 + int'(req1_valid && req1_ready) - int'(res1_valid && res1_ready);
            chk("ovf0", 32'(o0 <= 2), 32'd1);
            chk("ovf1", 32'(o1 <= 2), 32'd1);
        end
    end

    task automatic set_in(input logic v0, input logic [31:0] s0, input logic v1,
                          input logic [31:0] s1, input logic rr0, input logic rr1);
        @(negedge clk);
        req0_valid = v0;
        req0_src   = s0;
        req1_valid = v1;
        req1_src   = s1;
        res0_ready = rr0;
        res1_ready = rr1;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_src   = '0;
        req1_src   = '0;
        res0_ready = 1'b0;
        res1_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef FCONV_FIXED_PRIO_EN
    localparam int RR_N = 2;
`else
    localparam int RR_N = 6;
`endif

    initial begin
        rst     = 1'b1;
        req0_op = 1'b0;
        req1_op = 1'b1;
        do_reset();

        set_in(0, 0, 0, 0, 0, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_uv",   unit_valid, 0);
        chk("rst_rv0",  res0_valid, 0);
        chk("rst_rv1",  res1_valid, 0);
        chk("rst_rd0",  res0_data,  0);
        chk("rst_busy", busy,       0);

        for (int k = 0; k < 6; k++) begin
            logic e0;
`ifdef FCONV_FIXED_PRIO_EN
            e0 = 1'b1;
`else
            e0 = (k % 2 == 0);
`endif
            set_in(1, 32'h100 + 32'(k), 1, 32'h200 + 32'(k), 1, 1);
            if (k < RR_N) begin
                chk("rr_g0",  req0_ready, e0);
                chk("rr_g1",  req1_ready, !e0);
                chk("rr_op",  unit_op,    !e0);
                chk("rr_src", unit_src,   e0 ? 32'h100 + 32'(k) : 32'h200 + 32'(k));
            end
        end
        do_reset();

        set_in(1, 32'h3FC00000, 0, 0, 0, 0);
        chk("sg_rdy", req0_ready, 1);
        chk("sg_uv",  unit_valid, 1);
        chk("sg_src", unit_src,   32'h3FC00000);
        set_in(0, 0, 0, 0, 0, 0);
        chk("sg_busy1", busy, 1);
        chk("sg_rv1", res0_valid, 0);
        set_in(0, 0, 0, 0, 0, 0);
        chk("sg_rv2", res0_valid, 0);
        set_in(0, 0, 0, 0, 1, 0);
        chk("sg_rv3", res0_valid, 1);
        chk("sg_rd3", res0_data,  32'h2);
        chk("sg_busy3", busy, 1);
        set_in(0, 0, 0, 0, 0, 0);
        chk("sg_rv4", res0_valid, 0);
        chk("sg_busy4", busy, 0);
        do_reset();

        set_in(1, 32'h40400000, 0, 0, 0, 0);
        chk("bp_a0", req0_ready, 1);
        set_in(1, 32'hC0200000, 0, 0, 0, 0);
        chk("bp_a1", req0_ready, 1);
        set_in(1, 32'h3FC00000, 0, 0, 0, 0);
        chk("bp_a2", req0_ready, 0);
        set_in(1, 32'h3FC00000, 0, 0, 0, 0);
        chk("bp_a3", req0_ready, 0);
        chk("bp_d3", res0_data,  32'h3);
        set_in(1, 32'h3FC00000, 0, 0, 0, 0);
        chk("bp_a4", req0_ready, 0);
        chk("bp_v4", res0_valid, 1);
        set_in(1, 32'h3FC00000, 0, 0, 1, 0);
        chk("bp_a5", req0_ready, 0);
        chk("bp_d5", res0_data,  32'h3);
        set_in(1, 32'h3FC00000, 0, 0, 1, 0);
        chk("bp_a6", req0_ready, 1);
        chk("bp_d6", res0_data,  32'hFFFFFFFD);
        set_in(0, 0, 0, 0, 1, 0);
        chk("bp_v7", res0_valid, 0);
        do_reset();

        set_in(1, 32'h40400000, 0, 0, 0, 0);
        chk("pp_a0", req0_ready, 1);
        set_in(1, 32'hC0200000, 0, 0, 0, 0);
        chk("pp_a1", req0_ready, 1);
        set_in(0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 1, 0);
        chk("pp_v3", res0_valid, 1);
        chk("pp_d3", res0_data,  32'h3);
        set_in(0, 0, 0, 0, 0, 0);
        chk("pp_v4", res0_valid, 1);
        chk("pp_d4", res0_data,  32'hFFFFFFFD);
        set_in(0, 0, 0, 0, 1, 0);
        chk("pp_d5", res0_data,  32'hFFFFFFFD);
        set_in(0, 0, 0, 0, 0, 0);
        chk("pp_v6", res0_valid, 0);
        chk("pp_busy6", busy, 0);
        do_reset();

        set_in(0, 0, 1, 32'h500, 1, 0);
        chk("st_f0", req1_ready, 1);
        set_in(0, 0, 1, 32'h500, 1, 0);
        chk("st_f1", req1_ready, 1);
        for (int k = 0; k < 8; k++) begin
            set_in(1, 32'h600 + 32'(k), 1, 32'h500, 1, 0);
            chk("st_g0", req0_ready, (k % 4) < 2);
            chk("st_g1", req1_ready, 0);
        end
        chk("st_rd1", res1_data, 32'hFFFFFAFF);
        do_reset();

        set_in(1, 32'h40400000, 0, 0, 0, 0);
        chk("mr_a0", req0_ready, 1);
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("mr_uv",   unit_valid, 0);
        chk("mr_rv0",  res0_valid, 0);
        chk("mr_busy", busy,       0);
        set_in(1, 32'h700, 1, 32'h800, 0, 0);
        chk("mr_late", res0_valid, 0);
        chk("mr_p0",   req0_ready, 1);
        chk("mr_p1",   req1_ready, 0);
        set_in(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fconv_sched.md
# fconv_sched

Issue scheduler that shares one pipelined float/int conversion unit (ftoi / itof) between two requesters. It sits between the core's FP issue stage (requester 0) and the auxiliary FP sequencer (requester 1) on one side and the conversion datapath on the other. Requests are arbitrated round-robin and issued only when result space is guaranteed. Each result is returned in order to its own requester through a per-requester result buffer with valid/ready.

## Interface
- LAT, 2: fixed latency in cycles from `unit_valid` to `unit_result`; legal range 1..8.
- RDEPTH, 2: result buffer entries per requester; legal range 1..4.

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when `req0_valid` is also high
- req0_op  in  1  0 = ftoi, 1 = itof
- req0_src  in  32  operand
- req1_valid / req1_ready / req1_op / req1_src: same as the requester 0 ports, for requester 1
- unit_valid  out  1  issue strobe to the conversion unit
- unit_op  out  1  selected op
- unit_src  out  32  selected operand
- unit_result  in  32  conversion result, valid exactly LAT cycles after the `unit_valid` cycle
- res0_valid  out  1  result available for requester 0
- res0_ready  in  1  requester 0 consumes the result
- res0_data  out  32  result
- res1_valid / res1_ready / res1_data: same as the result 0 ports, for requester 1
- busy  out  1  any operation is in flight or any result buffer is non-empty

## Operation
- **Credit rule.** credit_i = RDEPTH − (occupancy_i + inflight_i). Requester i is eligible when req_i_valid = 1 and credit_i > 0.
- **Arbitration.**
  - One issue per cycle at most.
  - If only one requester is eligible, it wins.
  - If both are eligible, the one named by the 1-bit priority pointer `prio` wins.
  - After any grant, `prio` points to the other requester.
- **Request handshake.**
  - req_i_ready = grant_i, which is combinational and depends on req_i_valid.
  - A request may be held with valid high across stalls; its operands must stay stable until ready.
- **Issue.** unit_valid = grant0 | grant1. unit_op and unit_src are muxed from the winner. When idle they are 0.
- **Tracking.**
  - A LAT-deep shift register carries {valid, id}, pushed on issue.
  - At its output, unit_result is written to buffer[id].
- **Result buffers.**
  - One RDEPTH-entry FIFO per requester.
  - Push and pop in the same cycle are permitted.
  - Overflow cannot occur: a full buffer is impossible by the credit rule. The bench asserts this.
- **Ordering.** Results return in issue order per requester. No ordering is defined between requesters.
- **Reset.**
  - Outputs after reset: req*_ready = 0 unless granted, unit_valid = 0, res*_valid = 0, res*_data = 0, busy = 0.
  - Internal state after reset: prio = 0, FIFOs empty, tracker cleared.
  - Reset mid-operation drops in-flight tokens. Any unit_result arriving afterwards is ignored.

## Timing
- Accept in cycle T → unit_valid in T → write into the buffer at the edge ending T+LAT → res_valid high in T+LAT+1 if the buffer was empty.
- Pop: the edge with res_valid & res_ready advances the FIFO. The next entry is visible in the following cycle.
- Credit freed by a pop is usable in the cycle after the pop edge. Same-cycle pop does not create same-cycle credit.
- Back-to-back issue from one requester is sustained at 1 per cycle while credit > 0.
- busy is registered and reflects state after the current edge.

## Configuration
- `FCONV_FIXED_PRIO_EN`
  - Defined: requester 0 always wins when both are eligible; `prio` is unused.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- **Single op, latency.** Bench conversion model is ftoi with LAT = 2. req0 ftoi 0x3FC00000 (1.5) accepted at T → unit_valid at T; res0_valid at T+3 with res0_data = 0x00000002. busy is high until the pop.
- **Round-robin.** Both requesters valid continuously, both buffers drained every cycle → grants alternate 0,1,0,1… starting from requester 0 after reset. With `FCONV_FIXED_PRIO_EN` defined, all grants go to requester 0.
- **Backpressure.** RDEPTH = 2, res0_ready = 0, req0 streams 0x40400000 (3.0) and 0xC0200000 (−2.5) → exactly 2 accepts, then req0_ready = 0. Results 3 and 0xFFFFFFFD are held. Raising res0_ready restores acceptance one cycle after the first pop.
- **Simultaneous push/pop.** A buffer holding one entry pops while a new result arrives → occupancy stays 1 and the data order is preserved.
- **Ignored during stall.** req1 is starved by its full buffer while req0 flows → req0 receives every grant and req1 is never issued.
- **Reset mid-flight.** Assert rst one cycle after an issue → all valids are 0 next cycle. The late unit_result creates no res_valid. prio = 0.
